// File: rtl/i2c_bus_scheduler.sv
// Round-robin scheduler sharing one I2C master among four requesters, with a free-running
// 100 kHz tick enable, a post-transaction bus-idle guard interval and a transaction watchdog.
module i2c_bus_scheduler #(
  parameter int TICK_DIV      = 10,
  parameter int TIMEOUT_TICKS = 200,
  parameter int GUARD_TICKS   = 1
) (
  input  logic       CLK_1MHZ_IN,
  input  logic       RESET,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic       START,
  output logic       BUSY_OUT,
  output logic       TICK_100KHZ,
  output logic       TIMEOUT,
  output logic [1:0] TIMEOUT_ID
);
  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int TMO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int GUARD_W = (GUARD_TICKS > 0) ? $clog2(GUARD_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(TIMEOUT_TICKS);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_TICKS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_GUARD = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [1:0]         r_ptr, w_ptr_nxt;
  logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
  logic [GUARD_W-1:0] r_guard_cnt, w_guard_cnt_nxt;
  logic               r_start, w_start_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic [1:0]         r_timeout_id, w_timeout_id_nxt;
  logic [TICK_W-1:0]  r_tick_cnt;
  logic               w_tick;
  logic               w_tmo_hit;
  logic [1:0]         w_winner;
  logic [1:0]         w_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_tmo_hit = (r_tmo_cnt == TMO_LIMIT);

  // Descending scan so the requester closest after the last winner overwrites the others.
  always_comb begin
    w_winner = r_ptr;
    w_idx    = r_ptr;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_ptr + 2'(k);
      if (REQ[w_idx]) w_winner = w_idx;
    end
  end

  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd3;
      r_tmo_cnt    <= '0;
      r_guard_cnt  <= '0;
      r_start      <= 1'b0;
      r_timeout    <= 1'b0;
      r_timeout_id <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_guard_cnt  <= w_guard_cnt_nxt;
      r_start      <= w_start_nxt;
      r_timeout    <= w_timeout_nxt;
      r_timeout_id <= w_timeout_id_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold/default value first so no branch can infer a latch.
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_guard_cnt_nxt  = r_guard_cnt;
    w_start_nxt      = 1'b0;
    w_timeout_nxt    = 1'b0;
    w_timeout_id_nxt = r_timeout_id;

    case (r_state)
      S_IDLE: begin
        if (REQ != 4'b0000) begin
          w_state_nxt   = S_WAIT;
          w_ptr_nxt     = w_winner;
          w_tmo_cnt_nxt = '0;
          w_start_nxt   = 1'b1;
        end
      end
      S_WAIT: begin
        if (DONE || w_tmo_hit) begin
          // DONE takes precedence: an abort is only flagged when the master never answered.
          if (!DONE) begin
            w_timeout_nxt    = 1'b1;
            w_timeout_id_nxt = r_ptr;
          end
          if (GUARD_TICKS == 0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt     = S_GUARD;
            w_guard_cnt_nxt = GUARD_LOAD;
          end
        end else if (w_tick) begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_GUARD: begin
        if (r_guard_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          w_guard_cnt_nxt = r_guard_cnt - GUARD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign GNT         = (r_state == S_WAIT) ? (4'b0001 << r_ptr) : 4'b0000;
  assign START       = r_start;
  assign BUSY_OUT    = (r_state != S_IDLE);
  assign TICK_100KHZ = w_tick;
  assign TIMEOUT     = r_timeout;
  assign TIMEOUT_ID  = r_timeout_id;

endmodule

// File: tb/tb_i2c_bus_scheduler.sv
// Scoreboard bench for i2c_bus_scheduler: the driver plans each transaction on an edge timeline
// and queues the expected START/TIMEOUT events; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_i2c_bus_scheduler;
  localparam int  TD   = 10;
  localparam int  TO   = 200;
  localparam int  GT   = 1;
  localparam int  MAXE = 16384;
  localparam time HALF = 500;

  localparam int M_DONE = 0;
  localparam int M_TMO  = 1;
  localparam int M_COLL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] GNT;
  logic       START, BUSY_OUT, TICK_100KHZ, TIMEOUT;
  logic [1:0] TIMEOUT_ID;

  i2c_bus_scheduler #(.TICK_DIV(TD), .TIMEOUT_TICKS(TO), .GUARD_TICKS(GT)) dut (
    .CLK_1MHZ_IN(clk), .RESET(rst_n), .REQ(req), .DONE(done), .GNT(GNT), .START(START),
    .BUSY_OUT(BUSY_OUT), .TICK_100KHZ(TICK_100KHZ), .TIMEOUT(TIMEOUT), .TIMEOUT_ID(TIMEOUT_ID)
  );

  always #(HALF) clk = ~clk;

  typedef enum {EV_START, EV_TIMEOUT} ev_e;
  typedef struct {
    ev_e        ev;
    logic [3:0] val;
    logic [1:0] tid;
    int         at;
  } exp_t;

  exp_t     sb_q[$];
  bit [3:0] exp_gnt  [MAXE];
  bit       exp_busy [MAXE];

  int ecnt;
  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr = 3;
  int last_tid  = 0;
  int idle_from = 0;
  int req_set_e = 0;

  // Edges since the last reset release; the model timeline is expressed in this unit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t edge=%0d: got %0h, expected %0h", name, $time, ecnt, act, exp);
    end
  endtask

  function automatic int tick_after(input int e, input int n);
    return ((e / TD) + n) * TD;
  endfunction

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  function automatic int front_at(input ev_e k);
    if (sb_q.size() != 0 && sb_q[0].ev == k) return sb_q[0].at;
    return -1;
  endfunction

  task automatic wait_until(input int e);
    while (ecnt < e) @(negedge clk);
  endtask

  task automatic clear_model();
    for (int e = 0; e < MAXE; e++) begin
      exp_gnt[e]  = 4'b0000;
      exp_busy[e] = 1'b0;
    end
    sb_q.delete();
    model_ptr = 3;
    last_tid  = 0;
    idle_from = 0;
    req_set_e = 0;
  endtask

  // Plans one grant from the REQ currently applied, then drives it to its end.
  task automatic run_txn(input int mode, input int d, input logic [3:0] next_req, input bit stray);
    int s, w, x, ed, nidle;
    logic [3:0] oh;
    s  = ((idle_from > req_set_e) ? idle_from : req_set_e) + 1;
    w  = rr_pick(req, model_ptr);
    oh = 4'(1 << w);
    sb_q.push_back('{EV_START, oh, 2'(last_tid), s});
    model_ptr = w;
    ed = 0;
    case (mode)
      M_TMO: begin
        x = tick_after(s, TO) + 1;
        sb_q.push_back('{EV_TIMEOUT, oh, 2'(w), x});
        last_tid = w;
      end
      M_COLL: begin
        ed = tick_after(s, TO) + 1;
        x  = ed;
      end
      default: begin
        ed = s + d;
        x  = ed;
      end
    endcase
    nidle = (GT == 0) ? x : tick_after(x, GT) + 1;
    for (int e = s; e < nidle && e < MAXE; e++) begin
      exp_busy[e] = 1'b1;
      if (e < x) exp_gnt[e] = oh;
    end
    idle_from = nidle;
    wait_until(s);
    req       = next_req;
    req_set_e = s;
    if (mode == M_TMO) begin
      wait_until(x);
    end else begin
      wait_until(ed - 1);
      done = 1'b1;
      @(negedge clk);
      if (stray) @(negedge clk);
      done = 1'b0;
    end
  endtask

  // Idle period with a stray DONE pulse, then a new request pattern.
  task automatic idle_gap(input logic [3:0] m);
    wait_until(idle_from + int'($urandom_range(1, 15)));
    done = 1'b1;
    @(negedge clk);
    done      = 1'b0;
    req       = m;
    req_set_e = ecnt;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("tick", 32'(TICK_100KHZ), 32'(((ecnt + 1) % TD) == 0));
      if (ecnt < MAXE) begin
        check("gnt", 32'(GNT), 32'(exp_gnt[ecnt]));
        check("busy", 32'(BUSY_OUT), 32'(exp_busy[ecnt]));
      end
      while (sb_q.size() != 0 && sb_q[0].at < ecnt) begin
        check("missed_event_edge", ecnt, sb_q[0].at);
        void'(sb_q.pop_front());
      end
      if (START) begin
        check("start_edge", ecnt, front_at(EV_START));
        if (front_at(EV_START) == ecnt) begin
          check("start_gnt", 32'(GNT), 32'(sb_q[0].val));
          check("start_timeout_id", 32'(TIMEOUT_ID), 32'(sb_q[0].tid));
          void'(sb_q.pop_front());
        end
      end
      if (TIMEOUT) begin
        check("timeout_edge", ecnt, front_at(EV_TIMEOUT));
        if (front_at(EV_TIMEOUT) == ecnt) begin
          check("timeout_id", 32'(TIMEOUT_ID), 32'(sb_q[0].tid));
          void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #(60_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    logic [3:0] nr;
    clear_model();
    repeat (3) @(posedge clk);
    #200;
    check("rst_gnt", 32'(GNT), 32'h0);
    check("rst_start", 32'(START), 32'h0);
    check("rst_busy", 32'(BUSY_OUT), 32'h0);
    check("rst_tick", 32'(TICK_100KHZ), 32'h0);
    check("rst_timeout", 32'(TIMEOUT), 32'h0);
    check("rst_timeout_id", 32'(TIMEOUT_ID), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    wait_until(35);
    req       = 4'b1111;
    req_set_e = ecnt;
    repeat (4) run_txn(M_DONE, 5, 4'b1111, 1'b0);
    run_txn(M_DONE, 5, 4'b0100, 1'b0);
    run_txn(M_DONE, 50, 4'b0100, 1'b0);
    run_txn(M_DONE, 50, 4'b0010, 1'b1);
    run_txn(M_TMO, 0, 4'b0000, 1'b0);
    idle_gap(4'b1000);
    run_txn(M_COLL, 0, 4'($urandom_range(1, 15)), 1'b0);

    for (int i = 0; i < 30; i++) begin
      nr = ($urandom_range(0, 4) == 0 || i == 29) ? 4'b0000 : 4'($urandom_range(1, 15));
      run_txn(M_DONE, int'($urandom_range(1, 60)), nr, 1'($urandom_range(0, 1)));
      if (nr == 4'b0000 && i != 29) idle_gap(4'($urandom_range(1, 15)));
    end

    wait_until(idle_from + 2);
    req       = 4'b0001;
    req_set_e = ecnt;
    s         = ((idle_from > req_set_e) ? idle_from : req_set_e) + 1;
    wait_until(s - 1);
    @(posedge clk);
    #2;
    check("pre_rst_start", 32'(START), 32'h1);
    check("pre_rst_gnt", 32'(GNT), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(GNT), 32'h0);
    check("midrst_busy", 32'(BUSY_OUT), 32'h0);
    check("midrst_start", 32'(START), 32'h0);
    check("midrst_timeout", 32'(TIMEOUT), 32'h0);
    check("midrst_timeout_id", 32'(TIMEOUT_ID), 32'h0);
    clear_model();
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(M_DONE, int'($urandom_range(1, 60)), 4'b0110, 1'b0);
    run_txn(M_DONE, int'($urandom_range(1, 60)), 4'($urandom_range(1, 15)), 1'b1);
    run_txn(M_DONE, int'($urandom_range(1, 60)), 4'b0000, 1'b0);
    wait_until(idle_from + 5);
    check("sb_drain", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_bus_scheduler.md
Name: i2c_bus_scheduler

Overview:
Shares the single I2C master among four sensor requesters on the 1 MHz system clock. Generates its own 100 kHz one-cycle tick enable, so no derived clock domains exist. Round-robin arbitration, a start/done handshake to the master, a bus-idle guard interval and a transaction timeout watchdog. Sits between the sensor polling logic and the I2C master.

Parameters:
TICK_DIV, 10, CLK_1MHZ_IN cycles per TICK_100KHZ pulse (min 2)
TIMEOUT_TICKS, 200, ticks in WAIT before a transaction is aborted (2 ms at default; min 1)
GUARD_TICKS, 1, ticks of enforced bus idle after each transaction (0 = none)

Ports:
CLK_1MHZ_IN  in  1  1 MHz system clock, all logic on rising edge
RESET  in  1  asynchronous, active-low reset
REQ  in  4  level request per requester; bit i = requester i
DONE  in  1  one-cycle pulse from I2C master: transaction finished
GNT  out  4  one-hot grant, held for the whole transaction
START  out  1  one-cycle pulse to I2C master to begin the granted transaction
BUSY_OUT  out  1  high in any state other than IDLE
TICK_100KHZ  out  1  one-cycle enable every TICK_DIV cycles
TIMEOUT  out  1  one-cycle pulse when a transaction is aborted
TIMEOUT_ID  out  2  index of the last aborted requester, held until the next abort

Behaviour:
- Reset (RESET=0, async): state IDLE; GNT=0, START=0, BUSY_OUT=0, TICK_100KHZ=0, TIMEOUT=0, TIMEOUT_ID=0; tick counter=0; RR pointer=3 (requester 0 has first priority); timeout and guard counters=0.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. TICK_100KHZ=1 in the cycle the counter equals TICK_DIV-1. The first tick occurs in the 10th rising edge after RESET releases. Runs free in all states.
- FSM states: IDLE, WAIT, GUARD.
- IDLE: if REQ!=0, pick the first set bit searching from ptr+1 upward, mod 4. On the next edge: GNT=onehot(winner), START=1 for that cycle only, ptr=winner, timeout counter=0, state WAIT. If REQ=0, stay in IDLE.
- WAIT: GNT held; REQ changes are ignored. Timeout counter increments on each TICK_100KHZ.
  - If DONE=1: on the next edge GNT=0 and go to GUARD, with the guard counter loaded to GUARD_TICKS. If GUARD_TICKS=0, go directly to IDLE instead.
  - Else if timeout counter==TIMEOUT_TICKS: do the same exit as DONE, and additionally TIMEOUT=1 for one cycle and TIMEOUT_ID=winner index.
  - DONE and the timeout condition in the same cycle: DONE wins; no TIMEOUT pulse.
- GUARD: GNT=0. Guard counter decrements on each tick. When it reaches 0, the next edge goes to IDLE. New requests are only arbitrated in IDLE.
- DONE outside WAIT is ignored.
- A single requester holding REQ high is re-granted back-to-back, with only the guard interval between grants.
- Reset mid-transaction: all outputs clear immediately. No START or TIMEOUT is generated on release.
- Counter widths: sized with $clog2 of the parameter values; no wrap inside a valid range.

Test Plan:
- Tick period: release reset, REQ=0 -> TICK_100KHZ high on cycles 10, 20, 30…; BUSY_OUT=0, GNT=0 throughout.
- Single request: REQ=4'b0100 -> next edge GNT=0100 and START=1 for 1 cycle; DONE pulse 50 cycles later -> GNT=0 next edge; GUARD lasts until the next tick; then regrant with START again.
- Round-robin: REQ=4'b1111 held, DONE returned 5 cycles after each START -> grant order 0001, 0010, 0100, 1000, 0001.
- Timeout: REQ=4'b0010, DONE never asserted, TIMEOUT_TICKS=200 -> TIMEOUT pulse about 2000 cycles after START; TIMEOUT_ID=1; GNT drops; BUSY_OUT goes low after GUARD.
- Collision: DONE asserted in the same cycle the timeout is reached -> no TIMEOUT pulse; TIMEOUT_ID unchanged from its prior value.
- Reset mid-WAIT: assert RESET=0 asynchronously between edges -> GNT, BUSY_OUT, START and TIMEOUT are 0 immediately; after release, REQ=0001 is granted first.
